// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx among NUM_SRC byte-source FIFOs.
// Grants are handed out round-robin, and each grant lasts for at most MAX_BURST bytes. While a
// source holds the grant, its FIFO is presented to uart_tx as if it were the one FIFO uart_tx
// reads from. Line-format changes (data bits, stop bits, parity) are held in shadow registers.
// They are applied only between grants, and only while uart_tx is not busy.
//
// Optional feature: define UART_TX_SCHED_TAG_EN to send a tag byte {4'hA, 2'b00, id[1:0]}
// ahead of each burst.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   src_data/empty/en  per-source FIFO head byte, empty flag, arbitration enable
//   src_rden           per-source FIFO pop
//   tx_data/tx_empty   virtual FIFO presented to uart_tx
//   tx_rden, tx_busy   pop and busy from uart_tx
//   cfg_*, cfg_wr      requested line format and its write strobe
//   num_data_bits, stop_bits, parity  applied line format to uart_tx
//   cfg_pending        a written format is waiting to be applied
//   grant_valid/id     current owner of uart_tx

package uart_tx_sched_pkg;
  typedef enum logic [1:0] {
    STOP_BITS_1   = 2'd0,
    STOP_BITS_1P5 = 2'd1,
    STOP_BITS_2   = 2'd2
  } stop_bits_t;

  typedef enum logic [2:0] {
    PARITY_NONE  = 3'd0,
    PARITY_ODD   = 3'd1,
    PARITY_EVEN  = 3'd2,
    PARITY_MARK  = 3'd3,
    PARITY_SPACE = 3'd4
  } parity_t;
endpackage

module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned IdW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0][7:0] src_data,
  input  logic [NUM_SRC-1:0]      src_empty,
  output logic [NUM_SRC-1:0]      src_rden,
  input  logic [NUM_SRC-1:0]      src_en,
  output logic [7:0]              tx_data,
  output logic                    tx_empty,
  input  logic                    tx_rden,
  input  logic                    tx_busy,
  input  logic [3:0]              cfg_num_data_bits,
  input  stop_bits_t              cfg_stop_bits,
  input  parity_t                 cfg_parity,
  input  logic                    cfg_wr,
  output logic [3:0]              num_data_bits,
  output stop_bits_t              stop_bits,
  output parity_t                 parity,
  output logic                    cfg_pending,
  output logic                    grant_valid,
  output logic [IdW-1:0]          grant_id
);

`ifdef UART_TX_SCHED_TAG_EN
  typedef enum logic [1:0] {S_IDLE, S_TAG, S_XFER, S_CFG} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_CFG} state_t;
`endif

  state_t         state_q, state_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IdW-1:0] grant_id_q, grant_id_d;
  logic [IdW-1:0] last_grant_q, last_grant_d;
  logic [3:0]     burst_q, burst_d;
  logic           cfg_pending_q, cfg_pending_d;
  logic [3:0]     sh_bits_q, sh_bits_d;
  stop_bits_t     sh_stop_q, sh_stop_d;
  parity_t        sh_par_q, sh_par_d;
  logic [3:0]     app_bits_q, app_bits_d;
  stop_bits_t     app_stop_q, app_stop_d;
  parity_t        app_par_q, app_par_d;

  logic [NUM_SRC-1:0] eligible;
  logic               pick_found;
  logic [IdW-1:0]     pick_id;
  logic [IdW-1:0]     idx_w;
  int unsigned        idx;
  logic [3:0]         burst_inc;
  logic               release_grant;
`ifdef UART_TX_SCHED_TAG_EN
  logic [1:0]         gid2;
`endif

  // Round-robin pick: first eligible index after last_grant, wrapping.
  always_comb begin
    eligible   = src_en & ~src_empty;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    idx_w      = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      idx   = (32'(last_grant_q) + i) % NUM_SRC;
      idx_w = IdW'(idx);
      if (!pick_found && eligible[idx_w]) begin
        pick_found = 1'b1;
        pick_id    = idx_w;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    burst_d       = burst_q;
    cfg_pending_d = cfg_pending_q;
    sh_bits_d     = sh_bits_q;
    sh_stop_d     = sh_stop_q;
    sh_par_d      = sh_par_q;
    app_bits_d    = app_bits_q;
    app_stop_d    = app_stop_q;
    app_par_d     = app_par_q;
    tx_data       = 8'h00;
    tx_empty      = 1'b1;
    src_rden      = '0;
    burst_inc     = burst_q + 4'd1;
    release_grant = 1'b0;
`ifdef UART_TX_SCHED_TAG_EN
    gid2          = 2'(grant_id_q);
`endif

    case (state_q)
      S_IDLE: begin
        // A pending format change wins over new grants so it cannot be starved.
        if (cfg_pending_q && !tx_busy) begin
          state_d = S_CFG;
        end else if (pick_found) begin
          grant_valid_d = 1'b1;
          grant_id_d    = pick_id;
          burst_d       = '0;
`ifdef UART_TX_SCHED_TAG_EN
          state_d       = S_TAG;
`else
          state_d       = S_XFER;
`endif
        end
      end
`ifdef UART_TX_SCHED_TAG_EN
      S_TAG: begin
        tx_data  = {4'hA, 2'b00, gid2};
        tx_empty = 1'b0;
        if (tx_rden) begin
          state_d = S_XFER;
        end
      end
`endif
      S_XFER: begin
        tx_data                = src_data[grant_id_q];
        tx_empty               = src_empty[grant_id_q];
        src_rden[grant_id_q]   = tx_rden;
        if (tx_rden) begin
          burst_d = burst_inc;
          if (burst_inc == 4'(MAX_BURST)) begin
            release_grant = 1'b1;
          end
        end else if (src_empty[grant_id_q]) begin
          release_grant = 1'b1;
        end
      end
      S_CFG: begin
        app_bits_d    = sh_bits_q;
        app_stop_d    = sh_stop_q;
        app_par_d     = sh_par_q;
        cfg_pending_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (release_grant) begin
      state_d       = S_IDLE;
      grant_valid_d = 1'b0;
      last_grant_d  = grant_id_q;
    end

    // Placed after the S_CFG copy so a write in that same cycle stays pending.
    if (cfg_wr) begin
      sh_bits_d     = cfg_num_data_bits;
      sh_stop_d     = cfg_stop_bits;
      sh_par_d      = cfg_parity;
      cfg_pending_d = 1'b1;
    end

    // A burst cut short by reset must not pop one more byte.
    if (rst) begin
      src_rden = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant_q  <= IdW'(NUM_SRC - 1);
      burst_q       <= '0;
      cfg_pending_q <= 1'b0;
      sh_bits_q     <= 4'd8;
      sh_stop_q     <= STOP_BITS_1;
      sh_par_q      <= PARITY_NONE;
      app_bits_q    <= 4'd8;
      app_stop_q    <= STOP_BITS_1;
      app_par_q     <= PARITY_NONE;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      burst_q       <= burst_d;
      cfg_pending_q <= cfg_pending_d;
      sh_bits_q     <= sh_bits_d;
      sh_stop_q     <= sh_stop_d;
      sh_par_q      <= sh_par_d;
      app_bits_q    <= app_bits_d;
      app_stop_q    <= app_stop_d;
      app_par_q     <= app_par_d;
    end
  end

  assign num_data_bits = app_bits_q;
  assign stop_bits     = app_stop_q;
  assign parity        = app_par_q;
  assign cfg_pending   = cfg_pending_q;
  assign grant_valid   = grant_valid_q;
  assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched. Byte FIFOs and a randomly-popping uart_tx are modelled
// here; the expected grant sequence is planned from FIFO occupancy and round-robin order.
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  localparam int unsigned NSrc     = 4;
  localparam int unsigned MaxBurst = 8;
  localparam int          Depth    = 1024;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSrc-1:0][7:0] src_data;
  logic [NSrc-1:0]      src_empty;
  logic [NSrc-1:0]      src_rden;
  logic [NSrc-1:0]      src_en;
  logic [7:0]           tx_data;
  logic                 tx_empty;
  logic                 tx_rden;
  logic                 tx_busy;
  logic [3:0]           cfg_num_data_bits;
  stop_bits_t           cfg_stop_bits;
  parity_t              cfg_parity;
  logic                 cfg_wr;
  logic [3:0]           num_data_bits;
  stop_bits_t           stop_bits;
  parity_t              parity;
  logic                 cfg_pending;
  logic                 grant_valid;
  logic [1:0]           grant_id;

  uart_tx_sched #(
    .NUM_SRC   (NSrc),
    .MAX_BURST (MaxBurst)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .src_data          (src_data),
    .src_empty         (src_empty),
    .src_rden          (src_rden),
    .src_en            (src_en),
    .tx_data           (tx_data),
    .tx_empty          (tx_empty),
    .tx_rden           (tx_rden),
    .tx_busy           (tx_busy),
    .cfg_num_data_bits (cfg_num_data_bits),
    .cfg_stop_bits     (cfg_stop_bits),
    .cfg_parity        (cfg_parity),
    .cfg_wr            (cfg_wr),
    .num_data_bits     (num_data_bits),
    .stop_bits         (stop_bits),
    .parity            (parity),
    .cfg_pending       (cfg_pending),
    .grant_valid       (grant_valid),
    .grant_id          (grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [NSrc][Depth];
  int         rd_ptr [NSrc];
  int         wr_ptr [NSrc];
  int         exp_id [$];
  int         exp_len [$];
  int         model_last;
  bit         prev_gv, in_burst, tag_due;
  int         cur_id, cur_len;
  logic [NSrc-1:0] last_rden;
  logic       last_txe, last_gv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      mem[k][wr_ptr[k] % Depth] = 8'($urandom);
      wr_ptr[k]++;
    end
  endtask

  task automatic drive_fifos();
    for (int k = 0; k < NSrc; k++) begin
      src_empty[k] = (rd_ptr[k] == wr_ptr[k]);
      src_data[k]  = src_empty[k] ? 8'h00 : mem[k][rd_ptr[k] % Depth];
    end
  endtask

  // Expected (source, length) of every burst that drains the currently enabled FIFOs.
  task automatic plan();
    int  cnt [NSrc];
    int  found, b;
    bit  done;
    for (int k = 0; k < NSrc; k++) cnt[k] = src_en[k] ? (wr_ptr[k] - rd_ptr[k]) : 0;
    done = 1'b0;
    for (int iter = 0; iter < 500 && !done; iter++) begin
      found = -1;
      for (int i = 1; i <= NSrc; i++) begin
        int c;
        c = (model_last + i) % NSrc;
        if (found < 0 && cnt[c] > 0) found = c;
      end
      if (found < 0) begin
        done = 1'b1;
      end else begin
        b = (cnt[found] < MaxBurst) ? cnt[found] : MaxBurst;
        exp_id.push_back(found);
        exp_len.push_back(b);
        cnt[found] -= b;
        model_last = found;
      end
    end
  endtask

  task automatic monitor();
    logic [NSrc-1:0] exp_rden;
    logic [1:0]      gid;
    bit              gv;
    gv  = grant_valid;
    gid = grant_id;
    if (!prev_gv && gv) begin
      chk("grant_expected", 32'(exp_id.size() > 0), 32'd1);
      in_burst = 1'b1;
      cur_id   = int'(gid);
      cur_len  = 0;
`ifdef UART_TX_SCHED_TAG_EN
      tag_due  = 1'b1;
`else
      tag_due  = 1'b0;
`endif
    end
    exp_rden = '0;
    if (gv && !tag_due && tx_rden) exp_rden[gid] = 1'b1;
    chk("src_rden", 32'(src_rden), 32'(exp_rden));
    if (gv) begin
      if (in_burst) chk("gid_stable", 32'(gid), 32'(cur_id));
      if (tag_due) begin
        chk("tag_not_empty", 32'(tx_empty), 32'd0);
        if (tx_rden) begin
          chk("tag_byte", 32'(tx_data), {24'd0, 4'hA, 2'b00, gid});
          tag_due = 1'b0;
        end
      end else begin
        chk("tx_empty_follow", 32'(tx_empty), 32'(src_empty[gid]));
        if (tx_rden) begin
          chk("data_byte", 32'(tx_data), 32'(mem[gid][rd_ptr[gid] % Depth]));
          cur_len++;
        end
      end
    end else begin
      chk("idle_tx_empty", 32'(tx_empty), 32'd1);
    end
    if (prev_gv && !gv && in_burst) begin
      in_burst = 1'b0;
      if (exp_id.size() > 0) begin
        chk("burst_id", 32'(cur_id), 32'(exp_id[0]));
        chk("burst_len", 32'(cur_len), 32'(exp_len[0]));
        void'(exp_id.pop_front());
        void'(exp_len.pop_front());
      end
    end
    prev_gv = gv;
  endtask

  task automatic tick(input bit mon, input bit force_rd);
    @(negedge clk);
    if (force_rd) tx_rden = 1'b1;
    else if (grant_valid) tx_rden = !tx_empty && ($urandom_range(0, 3) != 0);
    else tx_rden = ($urandom_range(0, 3) == 0);
    #1;
    last_rden = src_rden;
    last_txe  = tx_empty;
    last_gv   = grant_valid;
    if (mon) monitor();
    @(posedge clk);
    #1;
    for (int k = 0; k < NSrc; k++) begin
      if (last_rden[k] && rd_ptr[k] != wr_ptr[k]) rd_ptr[k]++;
    end
    cfg_wr = 1'b0;
    drive_fifos();
  endtask

  task automatic clear_model();
    model_last = NSrc - 1;
    prev_gv    = 1'b0;
    in_burst   = 1'b0;
    tag_due    = 1'b0;
    exp_id.delete();
    exp_len.delete();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cfg_wr  = 1'b0;
    tx_rden = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    drive_fifos();
  endtask

  task automatic run_until_done(input int limit);
    int n;
    n = 0;
    while (!(exp_id.size() == 0 && !prev_gv) && n < limit) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("done_in_time", 32'(n < limit), 32'd1);
    repeat (4) tick(1'b1, 1'b0);
  endtask

  initial begin
    int n;
    logic [8:0] old_fmt;
    rst = 1'b1;
    src_en = '1;
    tx_busy = 1'b0;
    tx_rden = 1'b0;
    cfg_wr = 1'b0;
    cfg_num_data_bits = 4'd8;
    cfg_stop_bits = STOP_BITS_1;
    cfg_parity = PARITY_NONE;
    for (int k = 0; k < NSrc; k++) begin
      rd_ptr[k] = 0;
      wr_ptr[k] = 0;
    end
    drive_fifos();

    // Reset state.
    do_reset();
    tx_rden = 1'b1;
    #1;
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_src_rden", 32'(src_rden), 32'd0);
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("rst_cfg_pending", 32'(cfg_pending), 32'd0);
    chk("rst_data_bits", 32'(num_data_bits), 32'd8);
    chk("rst_stop_bits", 32'(stop_bits), 32'(STOP_BITS_1));
    chk("rst_parity", 32'(parity), 32'(PARITY_NONE));
    tx_rden = 1'b0;

    // Three bytes in source 0 only.
    push(0, 3);
    drive_fifos();
    plan();
    run_until_done(200);

    // Two deep sources share the port in MAX_BURST chunks.
    do_reset();
    push(0, 20);
    push(1, 20);
    drive_fifos();
    plan();
    run_until_done(1000);

    // Disabled source is skipped even while it holds data.
    do_reset();
    push(0, 6);
    push(1, 6);
    push(2, 6);
    src_en = 4'b1101;
    drive_fifos();
    plan();
    run_until_done(500);
    chk("src1_untouched", 32'(wr_ptr[1] - rd_ptr[1]), 32'd6);

    // Dropping src_en mid-burst does not cut the burst short.
    src_en = '1;
    push(0, 5);
    drive_fifos();
    plan();
    n = 0;
    while (!(in_burst && cur_len >= 1) && n < 200) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("first_pop_seen", 32'(n < 200), 32'd1);
    src_en[0] = 1'b0;
    run_until_done(500);
    src_en = '1;

    // Format written mid-burst applies only once idle and uart_tx is not busy.
    do_reset();
    tx_busy = 1'b1;
    push(0, 12);
    push(1, 5);
    drive_fifos();
    plan();
    old_fmt = {4'd8, STOP_BITS_1, PARITY_NONE};
    n = 0;
    while (!(in_burst && cur_len >= 2) && n < 200) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("mid_burst_reached", 32'(n < 200), 32'd1);
    cfg_num_data_bits = 4'd7;
    cfg_stop_bits = STOP_BITS_2;
    cfg_parity = PARITY_EVEN;
    cfg_wr = 1'b1;
    tick(1'b1, 1'b0);
    chk("cfg_pending_set", 32'(cfg_pending), 32'd1);
    n = 0;
    while (!(exp_id.size() == 0 && !prev_gv) && n < 500) begin
      tick(1'b1, 1'b0);
      chk("fmt_held", 32'({num_data_bits, stop_bits, parity}), 32'(old_fmt));
      chk("pending_held", 32'(cfg_pending), 32'd1);
      n++;
    end
    chk("cfg_bursts_done", 32'(n < 500), 32'd1);
    tx_busy = 1'b0;
    n = 0;
    while (cfg_pending && n < 10) begin
      chk("fmt_old_until_apply", 32'({num_data_bits, stop_bits, parity}), 32'(old_fmt));
      tick(1'b1, 1'b0);
      n++;
    end
    chk("cfg_pending_clear", 32'(cfg_pending), 32'd0);
    chk("cfg_data_bits", 32'(num_data_bits), 32'd7);
    chk("cfg_stop_bits", 32'(stop_bits), 32'(STOP_BITS_2));
    chk("cfg_parity", 32'(parity), 32'(PARITY_EVEN));

    // A write landing on the apply cycle stays pending with the newer value.
    cfg_num_data_bits = 4'd6;
    cfg_stop_bits = STOP_BITS_1P5;
    cfg_parity = PARITY_ODD;
    cfg_wr = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    cfg_num_data_bits = 4'd5;
    cfg_stop_bits = STOP_BITS_1;
    cfg_parity = PARITY_MARK;
    cfg_wr = 1'b1;
    tick(1'b1, 1'b0);
    chk("race_first_bits", 32'(num_data_bits), 32'd6);
    chk("race_first_parity", 32'(parity), 32'(PARITY_ODD));
    chk("race_still_pending", 32'(cfg_pending), 32'd1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("race_second_bits", 32'(num_data_bits), 32'd5);
    chk("race_second_stop", 32'(stop_bits), 32'(STOP_BITS_1));
    chk("race_second_parity", 32'(parity), 32'(PARITY_MARK));
    chk("race_pending_clear", 32'(cfg_pending), 32'd0);

    // Random occupancy and enable masks.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NSrc; k++) push(k, int'($urandom_range(0, 20)));
      src_en = 4'($urandom);
      drive_fifos();
      plan();
      run_until_done(1500);
    end
    src_en = '1;
    drive_fifos();
    plan();
    run_until_done(3000);

    // Reset one cycle after a pop from source 3.
    push(3, 10);
    drive_fifos();
    n = 0;
    last_rden = '0;
    while (!last_rden[3] && n < 100) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("src3_popped", 32'(last_rden[3]), 32'd1);
    rst = 1'b1;
    push(0, 4);
    drive_fifos();
    tick(1'b0, 1'b0);
    rst = 1'b0;
    clear_model();
    tick(1'b0, 1'b1);
    chk("post_rst_rden", 32'(last_rden), 32'd0);
    chk("post_rst_tx_empty", 32'(last_txe), 32'd1);
    chk("post_rst_gv", 32'(last_gv), 32'd0);
    plan();
    chk("plan_src0_first", 32'(exp_id[0]), 32'd0);
    run_until_done(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
